pwm_step_sequencer: RTL and testbench

Sequencer for the 6-bit PWM square-wave datapath: holds a small programmable table of (duty, period-count) steps and plays them in order on one PWM output, optionally looping. It sits between a control source (switches/host registers) and the output pin, replacing hand-coded duty schedules with a loadable step table and a start/stop handshake.

---
 rtl/pwm_step_sequencer_pkg.sv | 15 +
 rtl/pwm_step_sequencer_if.sv | 34 +++
 rtl/pwm_step_sequencer_pwm_core.sv | 42 ++++
 rtl/pwm_step_sequencer.sv | 122 ++++++++++++
 tb/tb_pwm_step_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_step_sequencer_pkg.sv
// Shared defaults and FSM state type for the PWM step sequencer.
package pwm_step_sequencer_pkg;

    localparam int unsigned CNT_W_DEF = 6;
    localparam int unsigned STEPS_DEF = 4;
    localparam int unsigned REP_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pwm_step_sequencer_if.sv
// Control/status bundle between a control source and the step sequencer.
interface pwm_step_sequencer_if
    import pwm_step_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned STEPS = STEPS_DEF,
    parameter int unsigned REP_W = REP_W_DEF
);
    localparam int unsigned IDX_W = $clog2(STEPS);

    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [CNT_W-1:0] cfg_duty;
    logic [REP_W-1:0] cfg_periods;
    logic             start;
    logic             stop;
    logic             loop;
    logic             enable;
    logic             pulse;
    logic             busy;
    logic [IDX_W-1:0] step_idx;
    logic             done;

    modport master (
        output cfg_we, cfg_addr, cfg_duty, cfg_periods, start, stop, loop, enable,
        input  pulse, busy, step_idx, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_duty, cfg_periods, start, stop, loop, enable,
        output pulse, busy, step_idx, done
    );

endinterface

// File: rtl/pwm_step_sequencer_pwm_core.sv
// Free-running PWM counter with synchronous clear, duty compare and period-end flag.
module pwm_core
    import pwm_step_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic             below_o,
    output logic             period_end_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear and increment are separate so the count holds at 0 through LOAD into the first RUN cycle.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        below_o      = (count_q < duty_i);
        period_end_o = inc_i && (count_q == '1);
    end

endmodule

// File: rtl/pwm_step_sequencer.sv
// Plays a loadable table of (duty, period-count) steps on one PWM output, optionally looping.
module pwm_step_sequencer
    import pwm_step_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned STEPS = STEPS_DEF,
    parameter int unsigned REP_W = REP_W_DEF
) (
    input  logic                 sysclk,
    input  logic                 reset,
    pwm_step_sequencer_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(STEPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] act_duty_q;
    logic [REP_W-1:0] act_per_q;
    logic [CNT_W-1:0] tbl_duty_q [STEPS];
    logic [REP_W-1:0] tbl_per_q  [STEPS];

    logic below;
    logic period_end;
    logic load_skip;
    logic step_last;
    logic advance;
    logic finish;

    pwm_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_i        (sysclk),
        .rst_i        (reset),
        .clr_i        (state_d != ST_RUN),
        .inc_i        (state_q == ST_RUN),
        .duty_i       (act_duty_q),
        .below_o      (below),
        .period_end_o (period_end)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rep_q      <= '0;
            act_duty_q <= '0;
            act_per_q  <= '0;
            for (int unsigned i = 0; i < STEPS; i++) begin
                tbl_duty_q[i] <= '0;
                tbl_per_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            if (state_q == ST_LOAD) begin
                act_duty_q <= tbl_duty_q[idx_q];
                act_per_q  <= tbl_per_q[idx_q];
            end
            // A write landing in the same cycle as LOAD of that entry is seen at its next LOAD.
            if (bus.cfg_we) begin
                tbl_duty_q[bus.cfg_addr] <= bus.cfg_duty;
                tbl_per_q[bus.cfg_addr]  <= bus.cfg_periods;
            end
        end
    end

    always_comb begin
        load_skip = (state_q == ST_LOAD) && (tbl_per_q[idx_q] == '0);
        step_last = (state_q == ST_RUN) && period_end && (rep_q == act_per_q - REP_W'(1));
        advance   = load_skip || step_last;
        finish    = advance && (idx_q == LAST_IDX) && !bus.loop;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                rep_d = '0;
                if (bus.start && !bus.stop) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                rep_d = '0;
                if (!load_skip) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (period_end && !step_last) begin
                    rep_d = rep_q + REP_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = finish ? ST_DONE : ST_LOAD;
        end
        if ((state_q != ST_IDLE) && bus.stop) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            rep_d   = '0;
        end
    end

    always_comb begin
        bus.busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);
        bus.done     = (state_q == ST_DONE);
        bus.pulse    = (state_q == ST_RUN) && below && bus.enable;
        bus.step_idx = idx_q;
    end

endmodule

// File: tb/tb_pwm_step_sequencer.sv
// Bench for pwm_step_sequencer: vector table, directed multi-cycle sequences and random traffic vs a cycle-schedule model.
module tb_pwm_step_sequencer;
    import pwm_step_sequencer_pkg::*;

    localparam int unsigned CNT_W = CNT_W_DEF;
    localparam int unsigned STEPS = STEPS_DEF;
    localparam int unsigned REP_W = REP_W_DEF;
    localparam int unsigned IDX_W = $clog2(STEPS);
    localparam int NST = STEPS;
    localparam int PER = 1 << CNT_W;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    always #5 sysclk = ~sysclk;

    pwm_step_sequencer_if #(.CNT_W(CNT_W), .STEPS(STEPS), .REP_W(REP_W)) bus ();

    pwm_step_sequencer #(.CNT_W(CNT_W), .STEPS(STEPS), .REP_W(REP_W)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    // Model: a queue of the cycles still to be shown, expanded one step at a time.
    typedef struct {
        logic is_load;
        logic is_run;
        logic is_done;
        int   idx;
        int   duty;
        int   phase;
        logic last;
    } rec_t;

    typedef struct {
        int duty;
        int periods;
        int exp_done;
        int exp_high;
    } vec_t;

    rec_t mq[$];
    int   mduty [NST];
    int   mper  [NST];
    int   checks = 0;
    int   errors = 0;

    vec_t vecs [6];
    int   n, dn, hi, highs1, highs2, dones, nchg, prev_idx;
    int   idxseq [8];

    function automatic rec_t mk(logic l, logic r, logic d, int idx, int duty, int phase, logic last);
        rec_t x;
        x.is_load = l;
        x.is_run  = r;
        x.is_done = d;
        x.idx     = idx;
        x.duty    = duty;
        x.phase   = phase;
        x.last    = last;
        return x;
    endfunction

    function automatic void advance_from(int k);
        if (k == NST - 1 && !bus.loop) mq.push_back(mk(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0));
        else mq.push_back(mk(1'b1, 1'b0, 1'b0, (k + 1) % NST, 0, 0, 1'b0));
    endfunction

    task automatic model_edge();
        rec_t r;
        int   len;
        if (reset) begin
            mq.delete();
            for (int i = 0; i < NST; i++) begin
                mduty[i] = 0;
                mper[i]  = 0;
            end
        end else begin
            if (mq.size() == 0) begin
                if (bus.start && !bus.stop) mq.push_back(mk(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0));
            end else if (bus.stop) begin
                mq.delete();
            end else begin
                r = mq.pop_front();
                if (r.is_load) begin
                    if (mper[r.idx] != 0) begin
                        len = mper[r.idx] * PER;
                        for (int p = 0; p < len; p++)
                            mq.push_back(mk(1'b0, 1'b1, 1'b0, r.idx, mduty[r.idx], p, p == len - 1));
                    end else begin
                        advance_from(r.idx);
                    end
                end else if (r.is_run && r.last) begin
                    advance_from(r.idx);
                end
            end
            if (bus.cfg_we) begin
                mduty[bus.cfg_addr] = int'(bus.cfg_duty);
                mper[bus.cfg_addr]  = int'(bus.cfg_periods);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int ep, eb, ed, ei;
        ep = 0; eb = 0; ed = 0; ei = 0;
        if (mq.size() > 0) begin
            ei = mq[0].idx;
            eb = (mq[0].is_load || mq[0].is_run) ? 1 : 0;
            ed = mq[0].is_done ? 1 : 0;
            ep = (mq[0].is_run && ((mq[0].phase % PER) < mq[0].duty) && bus.enable) ? 1 : 0;
        end
        chk("model_pulse", int'(bus.pulse), ep);
        chk("model_busy", int'(bus.busy), eb);
        chk("model_done", int'(bus.done), ed);
        chk("model_step_idx", int'(bus.step_idx), ei);
    endtask

    task automatic step();
        @(posedge sysclk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic wr(input int a, input int d, input int p);
        bus.cfg_we      = 1'b1;
        bus.cfg_addr    = IDX_W'(a);
        bus.cfg_duty    = CNT_W'(d);
        bus.cfg_periods = REP_W'(p);
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic start_seq();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic run_until_done(input int bound, output int done_n, output int highs);
        int k;
        done_n = -1;
        highs  = 0;
        k      = 1;
        while (k < bound && done_n < 0) begin
            if (bus.done) done_n = k;
            if (bus.pulse) highs++;
            if (done_n < 0) begin
                step();
                k++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{duty: 0,  periods: 1, exp_done: 69,  exp_high: 0};
        vecs[1] = '{duty: 63, periods: 1, exp_done: 69,  exp_high: 63};
        vecs[2] = '{duty: 32, periods: 2, exp_done: 133, exp_high: 64};
        vecs[3] = '{duty: 1,  periods: 3, exp_done: 197, exp_high: 3};
        vecs[4] = '{duty: 0,  periods: 0, exp_done: 5,   exp_high: 0};
        vecs[5] = '{duty: 17, periods: 1, exp_done: 69,  exp_high: 17};

        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_duty = '0; bus.cfg_periods = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0; bus.enable = 1'b1;

        reset = 1'b1;
        step();
        step();
        chk("reset_pulse", int'(bus.pulse), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_step_idx", int'(bus.step_idx), 0);
        reset = 1'b0;
        step();

        // Single-step table vectors, entries 1..3 left cleared.
        for (int v = 0; v < 6; v++) begin
            wr(0, vecs[v].duty, vecs[v].periods);
            start_seq();
            run_until_done(1000, dn, hi);
            chk("vec_done_cycle", dn, vecs[v].exp_done);
            chk("vec_high_cycles", hi, vecs[v].exp_high);
            step();
            chk("vec_idle_busy", int'(bus.busy), 0);
        end

        // Four-entry table, no loop.
        wr(0, 63, 2);
        wr(1, 0, 0);
        wr(2, 32, 1);
        wr(3, 0, 0);
        start_seq();
        run_until_done(1000, dn, hi);
        chk("seq_done_cycle", dn, 197);
        chk("seq_high_cycles", hi, 158);
        step();
        chk("seq_done_one_cycle", int'(bus.done), 0);
        chk("seq_idle_busy", int'(bus.busy), 0);

        // Looping, live rewrite of entry 0, enable gating, then stop mid-RUN.
        bus.loop = 1'b1;
        start_seq();
        prev_idx = 0; nchg = 1; highs1 = 0; highs2 = 0; dones = 0;
        for (int i = 0; i < 8; i++) idxseq[i] = -1;
        idxseq[0] = 0;
        for (n = 1; n < 350; n++) begin
            if (bus.done) dones++;
            if (int'(bus.step_idx) != prev_idx) begin
                if (nchg < 8) idxseq[nchg] = int'(bus.step_idx);
                nchg++;
                prev_idx = int'(bus.step_idx);
            end
            if (n >= 2 && n <= 129 && bus.pulse) highs1++;
            if (n >= 198 && n <= 325 && bus.pulse) highs2++;
            bus.cfg_we = (n == 10);
            if (n == 10) begin
                bus.cfg_addr = '0; bus.cfg_duty = CNT_W'(16); bus.cfg_periods = REP_W'(2);
            end
            if (n >= 335 && n < 340) begin
                bus.enable = 1'b0;
                #1;
                chk("enable_gate_off", int'(bus.pulse), 0);
                bus.enable = 1'b1;
                #1;
                chk("enable_gate_on", int'(bus.pulse), 1);
            end
            step();
        end
        bus.cfg_we = 1'b0;
        chk("loop_pass1_step0_high", highs1, 126);
        chk("loop_pass2_step0_high", highs2, 32);
        chk("loop_done_count", dones, 0);
        chk("loop_idx_changes", nchg, 7);
        chk("loop_idx_0", idxseq[0], 0);
        chk("loop_idx_1", idxseq[1], 1);
        chk("loop_idx_2", idxseq[2], 2);
        chk("loop_idx_3", idxseq[3], 3);
        chk("loop_idx_4", idxseq[4], 0);
        chk("loop_idx_5", idxseq[5], 1);
        chk("loop_idx_6", idxseq[6], 2);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("stop_pulse", int'(bus.pulse), 0);
        chk("stop_busy", int'(bus.busy), 0);
        chk("stop_done", int'(bus.done), 0);
        bus.loop = 1'b0;

        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("startstop_busy", int'(bus.busy), 0);

        // Restart attempt while busy, then reset mid-RUN.
        start_seq();
        step(); step(); step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("restart_step_idx", int'(bus.step_idx), 0);
        chk("restart_busy", int'(bus.busy), 1);
        for (int k = 0; k < 15; k++) step();
        reset = 1'b1;
        step();
        chk("midrun_reset_pulse", int'(bus.pulse), 0);
        chk("midrun_reset_busy", int'(bus.busy), 0);
        chk("midrun_reset_done", int'(bus.done), 0);
        chk("midrun_reset_idx", int'(bus.step_idx), 0);
        reset = 1'b0;
        step();
        start_seq();
        run_until_done(1000, dn, hi);
        chk("cleared_done_cycle", dn, 5);
        chk("cleared_high_cycles", hi, 0);
        step();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.start  = ($urandom_range(0, 9) == 0);
            bus.stop   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 99) == 0) bus.loop = ~bus.loop;
            bus.enable = ($urandom_range(0, 3) != 0);
            bus.cfg_we = ($urandom_range(0, 19) == 0);
            bus.cfg_addr    = IDX_W'($urandom_range(0, NST - 1));
            bus.cfg_duty    = CNT_W'($urandom_range(0, PER - 1));
            bus.cfg_periods = REP_W'($urandom_range(0, 2));
            step();
        end
        bus.start = 1'b0; bus.cfg_we = 1'b0; bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
